// File: rtl/hasti_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter: address-phase grant, data-phase owner
// tracking, and a per-master response buffer for a master whose next address lost arbitration.
module hasti_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit RR_ENABLE  = 1'b1
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [ADDR_WIDTH-1:0] m0_haddr,
    input  logic                  m0_hwrite,
    input  logic                  m0_hmastlock,
    input  logic [2:0]            m0_hsize,
    input  logic [2:0]            m0_hburst,
    input  logic [3:0]            m0_hprot,
    input  logic [1:0]            m0_htrans,
    input  logic [DATA_WIDTH-1:0] m0_hwdata,
    output logic [DATA_WIDTH-1:0] m0_hrdata,
    output logic                  m0_hready,
    output logic                  m0_hresp,
    input  logic [ADDR_WIDTH-1:0] m1_haddr,
    input  logic                  m1_hwrite,
    input  logic                  m1_hmastlock,
    input  logic [2:0]            m1_hsize,
    input  logic [2:0]            m1_hburst,
    input  logic [3:0]            m1_hprot,
    input  logic [1:0]            m1_htrans,
    input  logic [DATA_WIDTH-1:0] m1_hwdata,
    output logic [DATA_WIDTH-1:0] m1_hrdata,
    output logic                  m1_hready,
    output logic                  m1_hresp,
    output logic [ADDR_WIDTH-1:0] s_haddr,
    output logic                  s_hwrite,
    output logic [2:0]            s_hsize,
    output logic [2:0]            s_hburst,
    output logic                  s_hmastlock,
    output logic [3:0]            s_hprot,
    output logic [1:0]            s_htrans,
    output logic [DATA_WIDTH-1:0] s_hwdata,
    input  logic [DATA_WIDTH-1:0] s_hrdata,
    input  logic                  s_hready,
    input  logic                  s_hresp,
    output logic                  s_hmaster
);

    logic [1:0]            req_s;
    logic [1:0]            owner_s;
    logic                  gnt_d, gnt_q;
    logic                  last_gnt_d, last_gnt_q;
    logic                  lock_d, lock_q;
    logic                  dp_valid_d, dp_valid_q;
    logic                  dp_owner_d, dp_owner_q;
    logic [1:0]            bufv_d, bufv_q;
    logic [1:0]            buf_resp_d, buf_resp_q;
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic                  req_gnt_s, blocked_s, accept_s, sel_lock_s;
    logic [1:0]            hready_s, hresp_s;
    logic [DATA_WIDTH-1:0] hrdata_s [2];

    assign req_s = {m1_htrans[1], m0_htrans[1]};

    // Grant selection; frozen while the slave stalls so its address phase stays stable.
    always_comb begin
        gnt_d = gnt_q;
        if (s_hready) begin
            if (lock_q) begin
                gnt_d = last_gnt_q;
            end else if (req_s[0] ^ req_s[1]) begin
                gnt_d = req_s[1];
            end else if (req_s[0] & req_s[1]) begin
                gnt_d = RR_ENABLE ? ~last_gnt_q : 1'b1;
            end else begin
                gnt_d = gnt_q;
            end
        end else begin
            gnt_d = gnt_q;
        end
    end

    // Ownership, acceptance and address/data-phase bookkeeping.
    always_comb begin
        owner_s[0] = dp_valid_q & (dp_owner_q == 1'b0);
        owner_s[1] = dp_valid_q & (dp_owner_q == 1'b1);
        req_gnt_s  = req_s[gnt_d];
        blocked_s  = bufv_q[gnt_d] & owner_s[gnt_d];
        accept_s   = s_hready & req_gnt_s & ~blocked_s;
        sel_lock_s = gnt_d ? m1_hmastlock : m0_hmastlock;
        dp_valid_d = dp_valid_q;
        dp_owner_d = dp_owner_q;
        last_gnt_d = last_gnt_q;
        lock_d     = lock_q;
        if (accept_s) begin
            dp_valid_d = 1'b1;
            dp_owner_d = gnt_d;
            last_gnt_d = gnt_d;
            lock_d     = sel_lock_s;
        end else if (s_hready) begin
            dp_valid_d = 1'b0;
        end else begin
            dp_valid_d = dp_valid_q;
        end
    end

    // Response buffers: park a completed response whose master is still waiting for the bus.
    always_comb begin
        bufv_d     = bufv_q;
        buf_resp_d = buf_resp_q;
        buf_data_d = buf_data_q;
        for (int n = 0; n < 2; n++) begin
            if (s_hready && owner_s[n] && req_s[n] && (gnt_d != 1'(n))) begin
                bufv_d[n]     = 1'b1;
                buf_resp_d[n] = s_hresp;
                buf_data_d[n] = s_hrdata;
            end else if (bufv_q[n] && s_hready && (gnt_d == 1'(n))) begin
                bufv_d[n] = 1'b0;
            end else begin
                bufv_d[n] = bufv_q[n];
            end
        end
    end

    // Per-master response routing: live slave response, buffered response, or idle.
    always_comb begin
        hready_s    = 2'b11;
        hresp_s     = 2'b00;
        hrdata_s[0] = s_hrdata;
        hrdata_s[1] = s_hrdata;
        for (int n = 0; n < 2; n++) begin
            if (!hresetn) begin
                hready_s[n] = 1'b1;
                hresp_s[n]  = 1'b0;
            end else if (owner_s[n]) begin
                hready_s[n] = s_hready & (~req_s[n] | (gnt_d == 1'(n)));
                hresp_s[n]  = s_hresp;
            end else if (bufv_q[n]) begin
                hready_s[n] = s_hready & (gnt_d == 1'(n));
                hresp_s[n]  = buf_resp_q[n];
                hrdata_s[n] = buf_data_q[n];
            end else begin
                hready_s[n] = ~req_s[n] | (s_hready & (gnt_d == 1'(n)));
                hresp_s[n]  = 1'b0;
            end
        end
    end

    // Slave-side address mux follows the grant; write data follows the data-phase owner.
    always_comb begin
        case (gnt_d)
            1'b0: begin
                s_haddr     = m0_haddr;
                s_hwrite    = m0_hwrite;
                s_hsize     = m0_hsize;
                s_hburst    = m0_hburst;
                s_hmastlock = m0_hmastlock;
                s_hprot     = m0_hprot;
                s_htrans    = m0_htrans;
            end
            default: begin
                s_haddr     = m1_haddr;
                s_hwrite    = m1_hwrite;
                s_hsize     = m1_hsize;
                s_hburst    = m1_hburst;
                s_hmastlock = m1_hmastlock;
                s_hprot     = m1_hprot;
                s_htrans    = m1_htrans;
            end
        endcase
        if (!hresetn || !req_gnt_s || blocked_s) begin
            s_htrans = 2'b00;
        end else begin
            s_htrans = s_htrans;
        end
        s_hmaster = hresetn ? gnt_d : 1'b0;
        s_hwdata  = dp_owner_q ? m1_hwdata : m0_hwdata;
    end

    assign m0_hready = hready_s[0];
    assign m1_hready = hready_s[1];
    assign m0_hresp  = hresp_s[0];
    assign m1_hresp  = hresp_s[1];
    assign m0_hrdata = hrdata_s[0];
    assign m1_hrdata = hrdata_s[1];

    // State registers; reset drops any in-flight transfer and buffered response.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            gnt_q         <= 1'b0;
            last_gnt_q    <= 1'b0;
            lock_q        <= 1'b0;
            dp_valid_q    <= 1'b0;
            dp_owner_q    <= 1'b0;
            bufv_q        <= 2'b00;
            buf_resp_q    <= 2'b00;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
        end else begin
            gnt_q         <= gnt_d;
            last_gnt_q    <= last_gnt_d;
            lock_q        <= lock_d;
            dp_valid_q    <= dp_valid_d;
            dp_owner_q    <= dp_owner_d;
            bufv_q        <= bufv_d;
            buf_resp_q    <= buf_resp_d;
            buf_data_q[0] <= buf_data_d[0];
            buf_data_q[1] <= buf_data_d[1];
        end
    end

endmodule

// File: tb/tb_hasti_arbiter.sv
// Directed scenarios plus randomized two-master traffic for hasti_arbiter, checked
// against a transaction-level model of two masters and a memory slave.
module tb_hasti_arbiter;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
    logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
    logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
    logic [3:0]  m0_hprot, m1_hprot;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic        s_hwrite, s_hmastlock, s_hready, s_hresp, s_hmaster;
    logic [2:0]  s_hsize, s_hburst;
    logic [3:0]  s_hprot;
    logic [1:0]  s_htrans;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state.
    logic [31:0] slave_mem [32];
    logic [31:0] gold [2][16];
    logic [31:0] aq0 [$];
    logic [31:0] aq1 [$];
    logic        a_valid [2], a_write [2], d_valid [2], d_write [2];
    logic [3:0]  a_idx [2], d_idx [2];
    logic [31:0] d_wdata [2];
    int          issued [2], done [2];
    logic        sd_valid, sd_write, last_acc;
    logic [4:0]  sd_idx;
    int          sd_wait;

    always #5 hclk = ~hclk;

    hasti_arbiter dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hmastlock(m0_hmastlock),
        .m0_hsize(m0_hsize), .m0_hburst(m0_hburst), .m0_hprot(m0_hprot),
        .m0_htrans(m0_htrans), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
        .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hmastlock(m1_hmastlock),
        .m1_hsize(m1_hsize), .m1_hburst(m1_hburst), .m1_hprot(m1_hprot),
        .m1_htrans(m1_htrans), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
        .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
        .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans),
        .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready),
        .s_hresp(s_hresp), .s_hmaster(s_hmaster)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic mid();
        @(negedge hclk);
    endtask

    function automatic logic [31:0] addr_of(input int m, input logic [3:0] i);
        return (m == 0 ? 32'h0000_1000 : 32'h0000_2000) | {26'd0, i, 2'b00};
    endfunction

    function automatic logic [31:0] init_word(input int k);
        return 32'hA5C3_0000 + 32'(k) * 32'h0001_0203;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) slave_mem[k] = init_word(k);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) gold[m][i] = init_word(m * 16 + i);
            a_valid[m] = 1'b0;
            d_valid[m] = 1'b0;
            issued[m]  = 0;
            done[m]    = 0;
        end
        aq0.delete();
        aq1.delete();
        sd_valid = 1'b0;
        sd_wait  = 0;
        last_acc = 1'b0;
    endtask

    // One master's view of the edge about to happen: retire data phase, advance address phase.
    task automatic master_update(input int m, input logic hr, input logic [31:0] rd,
                                 input logic rp, input int n, input int pct);
        if (hr) begin
            if (d_valid[m]) begin
                if (d_write[m]) gold[m][d_idx[m]] = d_wdata[m];
                else chk(m == 0 ? "m0_rdata" : "m1_rdata", rd, gold[m][d_idx[m]]);
                chk(m == 0 ? "m0_resp" : "m1_resp", {31'd0, rp}, 32'd0);
                done[m]++;
                d_valid[m] = 1'b0;
            end
            if (a_valid[m]) begin
                d_valid[m] = 1'b1;
                d_idx[m]   = a_idx[m];
                d_write[m] = a_write[m];
                d_wdata[m] = $urandom;
                a_valid[m] = 1'b0;
            end
            if (issued[m] < n && $urandom_range(0, 99) < pct) begin
                a_valid[m] = 1'b1;
                a_idx[m]   = 4'($urandom_range(0, 15));
                a_write[m] = 1'($urandom_range(0, 1));
                issued[m]++;
                if (m == 0) aq0.push_back(addr_of(0, a_idx[0]));
                else aq1.push_back(addr_of(1, a_idx[1]));
            end
        end
    endtask

    task automatic run_random(input int n, input int pct, input int maxw);
        logic [31:0] exp_addr;
        for (int cyc = 0; cyc < 4000 && !(done[0] == n && done[1] == n); cyc++) begin
            m0_htrans = a_valid[0] ? 2'b10 : 2'b00;
            m0_haddr  = addr_of(0, a_idx[0]);
            m0_hwrite = a_write[0];
            m0_hwdata = (d_valid[0] && d_write[0]) ? d_wdata[0] : $urandom;
            m1_htrans = a_valid[1] ? 2'b10 : 2'b00;
            m1_haddr  = addr_of(1, a_idx[1]);
            m1_hwrite = a_write[1];
            m1_hwdata = (d_valid[1] && d_write[1]) ? d_wdata[1] : $urandom;
            s_hready  = !(sd_valid && sd_wait != 0);
            s_hrdata  = (sd_valid && !sd_write && sd_wait == 0) ? slave_mem[sd_idx] : $urandom;
            s_hresp   = 1'b0;
            mid();
            if (s_hready) begin
                if (sd_valid && sd_write) slave_mem[sd_idx] = s_hwdata;
                sd_valid = 1'b0;
                if (s_htrans[1]) begin
                    if (s_hmaster == 1'b0) exp_addr = (aq0.size() > 0) ? aq0.pop_front() : 32'hFFFF_FFFF;
                    else exp_addr = (aq1.size() > 0) ? aq1.pop_front() : 32'hFFFF_FFFF;
                    chk("acc_addr", s_haddr, exp_addr);
                    if (a_valid[0] && a_valid[1]) chk("rr_alternate", {31'd0, s_hmaster}, {31'd0, ~last_acc});
                    last_acc = s_hmaster;
                    sd_valid = 1'b1;
                    sd_idx   = {s_haddr[13], s_haddr[5:2]};
                    sd_write = s_hwrite;
                    sd_wait  = $urandom_range(0, maxw);
                end
            end else begin
                sd_wait--;
            end
            master_update(0, m0_hready, m0_hrdata, m0_hresp, n, pct);
            master_update(1, m1_hready, m1_hrdata, m1_hresp, n, pct);
            step();
        end
        chk("m0_done", 32'(done[0]), 32'(n));
        chk("m1_done", 32'(done[1]), 32'(n));
    endtask

    initial begin
        hresetn = 1'b0;
        m0_haddr = 32'd0; m0_hwrite = 1'b0; m0_hmastlock = 1'b0; m0_hwdata = 32'd0;
        m0_hsize = 3'd0; m0_hburst = 3'd0; m0_hprot = 4'h0; m0_htrans = 2'b10;
        m1_haddr = 32'd0; m1_hwrite = 1'b0; m1_hmastlock = 1'b0; m1_hwdata = 32'd0;
        m1_hsize = 3'd2; m1_hburst = 3'd1; m1_hprot = 4'h3; m1_htrans = 2'b10;
        s_hrdata = 32'd0; s_hready = 1'b1; s_hresp = 1'b0;
        #2;
        chk("rst_m0_hready", {31'd0, m0_hready}, 32'd1);
        chk("rst_m1_hready", {31'd0, m1_hready}, 32'd1);
        chk("rst_htrans", {30'd0, s_htrans}, 32'd0);
        chk("rst_hmaster", {31'd0, s_hmaster}, 32'd0);
        chk("rst_m0_hresp", {31'd0, m0_hresp}, 32'd0);

        // Simultaneous requests after reset: m1 first, then m0.
        mid();
        m0_haddr = 32'h200; m1_haddr = 32'h300; hresetn = 1'b1;
        #1;
        chk("sim_addr1", s_haddr, 32'h300);
        chk("sim_master1", {31'd0, s_hmaster}, 32'd1);
        chk("sim_hsize", {29'd0, s_hsize}, 32'd2);
        chk("sim_hburst", {29'd0, s_hburst}, 32'd1);
        chk("sim_hprot", {28'd0, s_hprot}, 32'h3);
        chk("sim_m0_hready_lo", {31'd0, m0_hready}, 32'd0);
        chk("sim_m1_hready", {31'd0, m1_hready}, 32'd1);
        step();
        m1_htrans = 2'b00; s_hrdata = 32'h1111_2222;
        mid();
        chk("sim_addr2", s_haddr, 32'h200);
        chk("sim_master2", {31'd0, s_hmaster}, 32'd0);
        chk("sim_m0_hready_hi", {31'd0, m0_hready}, 32'd1);
        chk("sim_m1_rdata", m1_hrdata, 32'h1111_2222);
        step();
        m0_htrans = 2'b00; s_hrdata = 32'hDEAD_BEEF;
        mid();
        chk("single_m0_hready", {31'd0, m0_hready}, 32'd1);
        chk("single_m0_rdata", m0_hrdata, 32'hDEAD_BEEF);
        chk("single_m1_hready", {31'd0, m1_hready}, 32'd1);
        chk("single_idle", {30'd0, s_htrans}, 32'd0);

        // Write with three slave wait states while m1 requests.
        step();
        m0_htrans = 2'b10; m0_haddr = 32'h400; m0_hwrite = 1'b1;
        mid();
        chk("ws_addr", s_haddr, 32'h400);
        chk("ws_hwrite", {31'd0, s_hwrite}, 32'd1);
        step();
        m0_htrans = 2'b00; m0_hwdata = 32'h55AA; m1_htrans = 2'b10; m1_haddr = 32'h500; s_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("ws_hold_master", {31'd0, s_hmaster}, 32'd0);
            chk("ws_hold_addr", s_haddr, 32'h400);
            chk("ws_hwdata", s_hwdata, 32'h55AA);
            chk("ws_m1_held", {31'd0, m1_hready}, 32'd0);
            chk("ws_m0_wait", {31'd0, m0_hready}, 32'd0);
            step();
        end
        s_hready = 1'b1;
        mid();
        chk("ws_done_m0", {31'd0, m0_hready}, 32'd1);
        chk("ws_m1_grant", {31'd0, s_hmaster}, 32'd1);
        chk("ws_m1_addr", s_haddr, 32'h500);
        step();
        m1_htrans = 2'b00; m0_hwrite = 1'b0;
        mid();
        chk("ws_m1_done", {31'd0, m1_hready}, 32'd1);

        // Locked sequence from m0 holds off m1 until an unlocked transfer is accepted.
        step();
        m0_htrans = 2'b10; m0_haddr = 32'h600; m0_hmastlock = 1'b1;
        m1_htrans = 2'b10; m1_haddr = 32'h700;
        mid();
        chk("lock_g1", {31'd0, s_hmaster}, 32'd0);
        chk("lock_hmastlock", {31'd0, s_hmastlock}, 32'd1);
        step();
        m0_haddr = 32'h604;
        mid();
        chk("lock_g2", {31'd0, s_hmaster}, 32'd0);
        chk("lock_addr2", s_haddr, 32'h604);
        chk("lock_m1_held", {31'd0, m1_hready}, 32'd0);
        chk("lock_m0_ready", {31'd0, m0_hready}, 32'd1);
        step();
        m0_haddr = 32'h608; m0_hmastlock = 1'b0;
        mid();
        chk("lock_g3", {31'd0, s_hmaster}, 32'd0);
        step();
        m0_htrans = 2'b00;
        mid();
        chk("lock_release", {31'd0, s_hmaster}, 32'd1);
        chk("lock_m1_addr", s_haddr, 32'h700);
        chk("lock_m1_ready", {31'd0, m1_hready}, 32'd1);
        step();
        m1_htrans = 2'b00;
        mid();

        // Two-cycle ERROR response to m1.
        step();
        m1_htrans = 2'b10; m1_haddr = 32'hA00;
        mid();
        chk("err_grant", {31'd0, s_hmaster}, 32'd1);
        step();
        m1_htrans = 2'b00; s_hready = 1'b0; s_hresp = 1'b1;
        mid();
        chk("err1_hresp", {31'd0, m1_hresp}, 32'd1);
        chk("err1_hready", {31'd0, m1_hready}, 32'd0);
        chk("err1_m0_hresp", {31'd0, m0_hresp}, 32'd0);
        step();
        s_hready = 1'b1;
        mid();
        chk("err2_hresp", {31'd0, m1_hresp}, 32'd1);
        chk("err2_hready", {31'd0, m1_hready}, 32'd1);
        step();
        s_hresp = 1'b0;

        // Reset in the middle of an m0 data phase.
        m0_htrans = 2'b10; m0_haddr = 32'hB00;
        mid();
        step();
        m0_htrans = 2'b00; m1_htrans = 2'b10; s_hready = 1'b0;
        mid();
        chk("mr_m0_wait", {31'd0, m0_hready}, 32'd0);
        #1 hresetn = 1'b0;
        #1;
        chk("mr_m0_hready", {31'd0, m0_hready}, 32'd1);
        chk("mr_m1_hready", {31'd0, m1_hready}, 32'd1);
        chk("mr_htrans", {30'd0, s_htrans}, 32'd0);
        chk("mr_hmaster", {31'd0, s_hmaster}, 32'd0);
        m1_htrans = 2'b00; s_hresp = 1'b1;
        step();
        mid();
        hresetn = 1'b1;
        #1;
        chk("mr_discard_hresp", {31'd0, m0_hresp}, 32'd0);
        chk("mr_discard_hready", {31'd0, m0_hready}, 32'd1);
        s_hresp = 1'b0; s_hready = 1'b1;
        step();

        // Randomized traffic: continuous contention first, then sparse requests with wait states.
        model_reset();
        run_random(40, 100, 0);
        run_random(60, 60, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
